// File: rtl/bus_ram_slave.sv
// Word-organised single-port RAM slave with byte-lane writes and a fixed wait-state count.
// Every accepted request is acked exactly once; out-of-range accesses read zero and drop writes.
module bus_ram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_TURN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_wr_en;
  logic [31:0]   r_addr;
  logic [31:0]   r_wr_data;
  logic [3:0]    r_byte_en;
  logic [31:0]   r_rd_data;
  logic [31:0]   r_mem [MEM_WORDS];

  logic          w_src_wr;
  logic [31:0]   w_src_addr;
  logic [31:0]   w_src_data;
  logic [3:0]    w_src_be;
  logic [31:0]   w_word;
  logic          w_hit;
  logic [AW-1:0] w_idx;
  logic          w_commit;

  // With no wait states the access commits on the accept edge itself, so use the live bus.
  always_comb begin
    w_src_wr   = r_wr_en;
    w_src_addr = r_addr;
    w_src_data = r_wr_data;
    w_src_be   = r_byte_en;
    if (r_state == S_IDLE) begin
      w_src_wr   = i_wr_en;
      w_src_addr = i_addr;
      w_src_data = i_wr_data;
      w_src_be   = i_byte_en;
    end
  end

  assign w_word   = (w_src_addr - ADDR_BASE) >> 2;
  assign w_hit    = (w_src_addr >= ADDR_BASE) && (w_word < 32'(MEM_WORDS));
  assign w_idx    = w_word[AW-1:0];
  assign w_commit = !i_rst && (w_next == S_ACK);

  always_comb begin
    w_next = r_state;
    o_ack  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_bus_en) begin
          w_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        o_ack  = 1'b1;
        w_next = S_TURN;
      end
      S_TURN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_wr_en   <= 1'b0;
      r_addr    <= 32'h0;
      r_wr_data <= 32'h0;
      r_byte_en <= 4'h0;
      r_rd_data <= 32'h0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_bus_en) begin
        r_wr_en   <= i_wr_en;
        r_addr    <= i_addr;
        r_wr_data <= i_wr_data;
        r_byte_en <= i_byte_en;
        r_cnt     <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !w_src_wr) begin
        r_rd_data <= w_hit ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  // RAM array carries no reset; a reset before the commit edge discards the pending write.
  always_ff @(posedge i_clk) begin
    if (w_commit && w_src_wr && w_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_src_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_src_data[8*k +: 8];
        end
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_bus_ram_slave.sv
// Bench for bus_ram_slave: three instances (0, 1 and 3 wait states) driven in parallel and
// checked every cycle against a word-array memory model and an ack-time schedule.
module tb_bus_ram_slave;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  bus_en;
  logic [2:0]  wr_en;
  logic [2:0]  ack;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be    [3];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  int          exp_ack_cyc [3];
  logic        exp_wr      [3];
  logic [31:0] exp_addr    [3];
  logic [31:0] exp_data    [3];
  logic [3:0]  exp_be      [3];
  logic [31:0] exp_rd_hold [3];
  int          req_cnt     [3];
  int          ack_cnt     [3];
  logic [31:0] mdl [3][4096];

  bus_ram_slave #(.ADDR_BASE(32'h0), .MEM_WORDS(4096), .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
    .i_clk(clk), .i_rst(rst[0]), .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]), .i_addr(addr[0]),
    .i_wr_data(wdata[0]), .i_byte_en(be[0]), .o_ack(ack[0]), .o_rd_data(rdata[0]));
  bus_ram_slave #(.ADDR_BASE(32'h0), .MEM_WORDS(4096), .WAIT_STATES(1), .INIT_FILE("")) u_ws1 (
    .i_clk(clk), .i_rst(rst[1]), .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]), .i_addr(addr[1]),
    .i_wr_data(wdata[1]), .i_byte_en(be[1]), .o_ack(ack[1]), .o_rd_data(rdata[1]));
  bus_ram_slave #(.ADDR_BASE(32'h1000), .MEM_WORDS(4096), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
    .i_clk(clk), .i_rst(rst[2]), .i_bus_en(bus_en[2]), .i_wr_en(wr_en[2]), .i_addr(addr[2]),
    .i_wr_data(wdata[2]), .i_byte_en(be[2]), .o_ack(ack[2]), .o_rd_data(rdata[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h1000 : 32'h0;
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] a);
    return (a >= base_of(d)) && ((a - base_of(d)) < 32'h4000);
  endfunction

  function automatic int widx(input int d, input logic [31:0] a);
    return int'((a - base_of(d)) >> 2);
  endfunction

  function automatic void chk(input string nm, input int d, input logic [31:0] act,
                              input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s[dut%0d] cyc %0d: got %h required %h", nm, d, cyc, act, req);
    end
  endfunction

  function automatic logic [31:0] rnd_addr(input int d);
    int r;
    logic [31:0] lo;
    r  = $urandom_range(0, 15);
    lo = 32'($urandom_range(0, 3));
    if (r == 0) return base_of(d) + 32'h4000 + 32'($urandom_range(0, 63)) * 4 + lo;
    if (r == 1) return base_of(d) - 32'h4 - 32'($urandom_range(0, 63)) * 4 + lo;
    return base_of(d) + 32'($urandom_range(0, 63)) * 4 + lo;
  endfunction

  task automatic scramble(input int d);
    wr_en[d] = 1'($urandom_range(0, 1));
    addr[d]  = $urandom;
    wdata[d] = $urandom;
    be[d]    = 4'($urandom);
  endtask

  // Compare process: the model commits each access at its scheduled ack cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 3; d++) begin
          bit e;
          e = (cyc == exp_ack_cyc[d]);
          if (e) begin
            if (exp_wr[d]) begin
              if (in_rng(d, exp_addr[d])) begin
                for (int k = 0; k < 4; k++) begin
                  if (exp_be[d][k]) mdl[d][widx(d, exp_addr[d])][8*k +: 8] = exp_data[d][8*k +: 8];
                end
              end
            end else begin
              exp_rd_hold[d] = in_rng(d, exp_addr[d]) ? mdl[d][widx(d, exp_addr[d])] : 32'h0;
            end
          end
          if (ack[d]) ack_cnt[d]++;
          chk("ack", d, 32'(ack[d]), 32'(e));
          chk("rd_data", d, rdata[d], exp_rd_hold[d]);
        end
      end
    end
  end

  // One master transaction, issued in an IDLE cycle; returns in the next IDLE cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] b, input bit hold, output logic [31:0] rd,
                      output int lat, output int acyc);
    int k;
    bit got;
    got = 0; rd = 32'h0; lat = -1; acyc = -1;
    bus_en[d] = 1'b1; wr_en[d] = wr; addr[d] = a; wdata[d] = dat; be[d] = b;
    k = cyc;
    exp_wr[d] = wr; exp_addr[d] = a; exp_data[d] = dat; exp_be[d] = b;
    exp_ack_cyc[d] = k + 1 + ws_of(d);
    req_cnt[d]++;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack[d]) begin
        got = 1; lat = cyc - k; acyc = cyc; rd = rdata[d];
      end else begin
        @(posedge clk); #1;
        scramble(d);
      end
    end
    chk("ack_seen", d, 32'(got), 32'd1);
    @(posedge clk); #1;
    chk("ack_width", d, 32'(ack[d]), 32'd0);
    if (!hold) bus_en[d] = 1'b0;
    scramble(d);
    @(posedge clk); #1;
  endtask

  task automatic run_dut(input int d);
    logic [31:0] rd;
    int lat, a1, a2;
    bit w, hold;
    for (int i = 0; i < 64; i++) xfer(d, 1, base_of(d) + 32'(i * 4), $urandom, 4'hF, 0, rd, lat, a1);
    if (d == 1) begin
      xfer(d, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, lat, a1);
      chk("t1_wr_latency", d, 32'(lat), 32'd2);
      xfer(d, 0, 32'h10, 32'h0, 4'h0, 0, rd, lat, a1);
      chk("t1_rd_data", d, rd, 32'hDEADBEEF);
      xfer(d, 1, 32'h20, 32'h11223344, 4'hF, 0, rd, lat, a1);
      xfer(d, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, lat, a1);
      xfer(d, 0, 32'h20, 32'h0, 4'hF, 0, rd, lat, a1);
      chk("t2_lanes", d, rd, 32'h11BB33DD);
      xfer(d, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, lat, a1);
      xfer(d, 0, 32'h22, 32'h0, 4'h0, 0, rd, lat, a1);
      chk("t2_be0", d, rd, 32'h11BB33DD);
      xfer(d, 1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, lat, a1);
      xfer(d, 0, 32'h4000, 32'h0, 4'hF, 0, rd, lat, a1);
      chk("t3_oor_rd", d, rd, 32'h0);
      chk("t3_oor_latency", d, 32'(lat), 32'd2);
      xfer(d, 1, 32'h4000, 32'hCAFEF00D, 4'hF, 0, rd, lat, a1);
      xfer(d, 0, 32'h0, 32'h0, 4'h0, 0, rd, lat, a1);
      chk("t3_word0", d, rd, 32'h0BADF00D);
      xfer(d, 1, 32'h8, 32'h55AA55AA, 4'hF, 0, rd, lat, a1);
      bus_en[d] = 1'b1; wr_en[d] = 1'b1; addr[d] = 32'h8; wdata[d] = 32'h12345678; be[d] = 4'hF;
      @(posedge clk); #1;
      rst[d] = 1'b1; bus_en[d] = 1'b0; exp_ack_cyc[d] = -1;
      @(posedge clk); #1;
      rst[d] = 1'b0; exp_rd_hold[d] = 32'h0;
      chk("t5_ack", d, 32'(ack[d]), 32'd0);
      chk("t5_rd_clear", d, rdata[d], 32'h0);
      xfer(d, 0, 32'h8, 32'h0, 4'h0, 0, rd, lat, a1);
      chk("t5_old_word", d, rd, 32'h55AA55AA);
      chk("t5_idle_latency", d, 32'(lat), 32'd2);
    end
    if (d == 0) begin
      xfer(d, 1, 32'h30, 32'h01020304, 4'hF, 1, rd, lat, a1);
      chk("t4_ws0_latency", d, 32'(lat), 32'd1);
      xfer(d, 0, 32'h30, 32'h0, 4'h0, 1, rd, lat, a2);
      chk("t4_ack_spacing", d, 32'(a2 - a1), 32'd3);
      chk("t4_rd", d, rd, 32'h01020304);
      bus_en[d] = 1'b0;
    end
    if (d == 2) begin
      xfer(d, 1, 32'h1004, 32'h600DCAFE, 4'hF, 0, rd, lat, a1);
      chk("base_latency", d, 32'(lat), 32'd4);
      xfer(d, 0, 32'h1004, 32'h0, 4'h0, 0, rd, lat, a1);
      chk("base_rd", d, rd, 32'h600DCAFE);
      xfer(d, 0, 32'h0004, 32'h0, 4'h0, 0, rd, lat, a1);
      chk("below_base_rd", d, rd, 32'h0);
    end
    for (int t = 0; t < 2500; t++) begin
      w    = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      xfer(d, w, rnd_addr(d), $urandom, 4'($urandom), hold, rd, lat, a1);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    bus_en[d] = 1'b0;
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: cycle budget exhausted at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 3'b111; bus_en = 3'b000; wr_en = 3'b000;
    for (int d = 0; d < 3; d++) begin
      addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
      exp_ack_cyc[d] = -1; exp_wr[d] = 1'b0; exp_addr[d] = 32'h0; exp_data[d] = 32'h0;
      exp_be[d] = 4'h0; exp_rd_hold[d] = 32'h0; req_cnt[d] = 0; ack_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ack", d, 32'(ack[d]), 32'd0);
      chk("reset_rd_data", d, rdata[d], 32'h0);
    end
    rst = 3'b000;
    chk_en = 1'b1;
    fork
      run_dut(0);
      run_dut(1);
      run_dut(2);
    join
    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("ack_count", d, 32'(ack_cnt[d]), 32'(req_cnt[d]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
